// File: rtl/ascon_pkg.sv
// Shared definitions for the Ascon decryption sink: FSM state encoding
// and the fixed tag width.
package ascon_pkg;

  localparam int unsigned TAG_W = 128;

  typedef enum logic [2:0] {
    IDLE,
    CAPTURE,
    COMPARE,
    OUTPUT,
    DONE
  } state_t;

endpackage : ascon_pkg

// File: rtl/ascon_dec_sink_if.sv
// Handshake/bus bundle between the Ascon decryption core, the sink and the
// downstream consumer. master drives the sink inputs, slave is the sink.
interface ascon_dec_sink_if #(
  parameter int unsigned Y = 32,
  parameter int unsigned T = 128
);

  logic         decryption_readyxSI;
  logic         plain_textxSI;
  logic         tagxSI;
  logic [T-1:0] expected_tagxDI;
  logic         out_readyxSI;
  logic         out_validxSO;
  logic [Y-1:0] plain_textxDO;
  logic         tag_okxSO;
  logic         abortxSO;
  logic         busyxSO;

  modport master (
    output decryption_readyxSI,
    output plain_textxSI,
    output tagxSI,
    output expected_tagxDI,
    output out_readyxSI,
    input  out_validxSO,
    input  plain_textxDO,
    input  tag_okxSO,
    input  abortxSO,
    input  busyxSO
  );

  modport slave (
    input  decryption_readyxSI,
    input  plain_textxSI,
    input  tagxSI,
    input  expected_tagxDI,
    input  out_readyxSI,
    output out_validxSO,
    output plain_textxDO,
    output tag_okxSO,
    output abortxSO,
    output busyxSO
  );

endinterface : ascon_dec_sink_if

// File: rtl/ascon_sipo.sv
// Serial-in parallel-out shift register. New bits enter at the MSB, so the
// first bit shifted lands at the LSB after W shifts.
module ascon_sipo #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         shift_en,
  input  logic         clear,
  input  logic         bit_in,
  output logic [W-1:0] data
);

  // Shift register with synchronous clear taking priority over shift.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data <= '0;
    end else if (clear) begin
      data <= '0;
    end else if (shift_en) begin
      data <= {bit_in, data[W-1:1]};
    end
  end

endmodule : ascon_sipo

// File: rtl/ascon_dec_sink.sv
// Ascon decryption sink: captures the serial plaintext and computed tag
// from the core, checks the tag against the received one and releases the
// plaintext downstream only when the tag matches.
module ascon_dec_sink
  import ascon_pkg::*;
#(
  parameter int unsigned Y = 32,
  parameter int unsigned T = TAG_W
) (
  input logic             clk,
  input logic             rst,
  ascon_dec_sink_if.slave bus
);

  state_t       state, state_nx;
  logic         rdy_d;
  logic [7:0]   cnt, cnt_nx;
  logic         tag_ok_q, tag_ok_nx;
  logic         abort_q, abort_nx;
  logic         sample;
  logic         pt_shift;
  logic         clr;
  logic [Y-1:0] pt_q;
  logic [T-1:0] tag_q;

  // Ready is delayed one cycle because the core presents bit j one cycle
  // after asserting ready; sampling therefore keys off rdy_d.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_d <= 1'b0;
    end else begin
      rdy_d <= bus.decryption_readyxSI;
    end
  end

  // FSM and control register updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      tag_ok_q <= 1'b0;
      abort_q  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      tag_ok_q <= tag_ok_nx;
      abort_q  <= abort_nx;
    end
  end

  // Next-state logic, sample enables and register clears.
  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    tag_ok_nx = tag_ok_q;
    abort_nx  = 1'b0;
    sample    = 1'b0;
    clr       = 1'b0;
    case (state)
      IDLE: begin
        // The cycle that sees rdy_d high already carries sample 0.
        if (rdy_d) begin
          sample   = 1'b1;
          cnt_nx   = 8'd1;
          state_nx = CAPTURE;
        end
      end
      CAPTURE: begin
        if (!rdy_d) begin
          abort_nx = 1'b1;
          clr      = 1'b1;
          cnt_nx   = '0;
          state_nx = IDLE;
        end else begin
          sample = 1'b1;
          if (cnt == 8'(T - 1)) begin
            cnt_nx   = '0;
            state_nx = COMPARE;
          end else begin
            cnt_nx = cnt + 8'd1;
          end
        end
      end
      COMPARE: begin
        tag_ok_nx = (tag_q == bus.expected_tagxDI);
        state_nx  = OUTPUT;
      end
      OUTPUT: begin
        if (bus.out_readyxSI) begin
          state_nx = DONE;
        end
      end
      DONE: begin
        if (!rdy_d) begin
          clr       = 1'b1;
          tag_ok_nx = 1'b0;
          state_nx  = IDLE;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  assign pt_shift = sample && (cnt < 8'(Y));

  ascon_sipo #(.W(Y)) u_pt_sipo (
    .clk      (clk),
    .rst      (rst),
    .shift_en (pt_shift),
    .clear    (clr),
    .bit_in   (bus.plain_textxSI),
    .data     (pt_q)
  );

  ascon_sipo #(.W(T)) u_tag_sipo (
    .clk      (clk),
    .rst      (rst),
    .shift_en (sample),
    .clear    (clr),
    .bit_in   (bus.tagxSI),
    .data     (tag_q)
  );

  assign bus.out_validxSO  = (state == OUTPUT);
  assign bus.tag_okxSO     = (state == OUTPUT) && tag_ok_q;
  assign bus.plain_textxDO = ((state == OUTPUT) && tag_ok_q) ? pt_q : '0;
  assign bus.abortxSO      = abort_q;
  assign bus.busyxSO       = (state != IDLE);

endmodule : ascon_dec_sink

// File: doc/ascon_dec_sink.md
ASCON_DEC_SINK -- requirements
Module: ascon_dec_sink

Interface
REQ-001 SHALL have parameter Y, default 32, plaintext length in bits (2..128).
REQ-002 SHALL have parameter T, default 128, tag length in bits (fixed 128).
REQ-003 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port decryption_readyxSI  input  1  ready flag from the Ascon decryption core.
REQ-006 SHALL have port plain_textxSI  input  1  serial plaintext bit, LSB first.
REQ-007 SHALL have port tagxSI  input  1  serial computed-tag bit, LSB first.
REQ-008 SHALL have port expected_tagxDI  input  T  received tag to verify against, stable while busy.
REQ-009 SHALL have port out_readyxSI  input  1  downstream accept.
REQ-010 SHALL have port out_validxSO  output  1  result valid.
REQ-011 SHALL have port plain_textxDO  output  Y  verified plaintext, zero unless tag_okxSO.
REQ-012 SHALL have port tag_okxSO  output  1  tag comparison passed.
REQ-013 SHALL have port abortxSO  output  1  one-cycle pulse: capture aborted.
REQ-014 SHALL have port busyxSO  output  1  high in any state except IDLE.

Function
REQ-015 SHALL use states IDLE, CAPTURE, COMPARE, OUTPUT, DONE.
REQ-016 SHALL register decryption_readyxSI into rdy_d each cycle; serial bits are sampled while rdy_d=1, since the core presents bit j one cycle after its ready.
REQ-017 IDLE -> CAPTURE when rdy_d=1; that same cycle SHALL be sample 0.
REQ-018 In CAPTURE, sample counter cnt (8 bits) SHALL increment once per cycle from 0 to T-1.
REQ-019 Sample cnt<Y SHALL shift plain_textxSI into the plaintext register from the MSB side, so after Y samples bit 0 sits at LSB.
REQ-020 Every sample SHALL shift tagxSI into the tag register from the MSB side; after T samples bit 0 sits at LSB.
REQ-021 After sample T-1, SHALL enter COMPARE; COMPARE SHALL compute full T-bit equality (no early exit) into tag_ok register, then enter OUTPUT.
REQ-022 In OUTPUT, out_validxSO=1, plain_textxDO = tag_ok ? captured : 0; outputs SHALL hold stable until out_readyxSI=1.
REQ-023 Latency: out_validxSO SHALL rise 2 cycles after the cycle sampling bit T-1.
REQ-024 OUTPUT with out_readyxSI=1 SHALL go to DONE; out_validxSO low next cycle.
REQ-025 DONE SHALL wait for rdy_d=0, then go to IDLE; a new message requires ready to drop first.
REQ-026 If rdy_d falls during CAPTURE, SHALL pulse abortxSO one cycle, clear cnt and data registers, go to IDLE; no output is produced.
REQ-027 rdy_d falling during COMPARE or OUTPUT SHALL be ignored; result still delivered.
REQ-028 Captured registers SHALL be cleared to zero on the DONE->IDLE transition.

Reset
REQ-029 On rst=0, SHALL asynchronously force IDLE, cnt=0, rdy_d=0, all data registers 0, out_validxSO=0, plain_textxDO=0, tag_okxSO=0, abortxSO=0, busyxSO=0.
REQ-030 Reset mid-CAPTURE or mid-OUTPUT SHALL discard all captured data with no output pulse.

Structure
REQ-031 State encoding and constant TAG_W=128 SHALL reside in shared package ascon_pkg.
REQ-032 Shift capture SHALL use sub-module ascon_sipo (parameter W, shift-enable, clear), instantiated for plaintext and tag.

Verification
REQ-033 Ready rises, stream pt=0xDEADBEEF, tag=expected=0x0123..CDEF LSB-first -> out_valid 2 cycles after bit 127, plain_textxDO=0xDEADBEEF, tag_ok=1.
REQ-034 Same but expected_tag bit 127 flipped -> tag_ok=0, plain_textxDO=0.
REQ-035 Hold out_ready=0 for 10 cycles -> outputs stable; out_ready=1 -> DONE, valid low next cycle.
REQ-036 Drop ready after 50 samples -> abortxSO one pulse, busy low, no out_valid.
REQ-037 Assert rst=0 mid-CAPTURE (async, between edges) -> all outputs 0 immediately; restart capture yields correct result.
REQ-038 Keep ready high after handshake -> stays DONE; drop then re-raise -> second message captured correctly.
